mem_copy_master: RTL
====================

// Module: mem_copy_master
// PURPOSE
//  Bus initiator for the valid/ready/addr/rdata/wdata/wstrb memory port. It drives the port as a master.
//  It accepts one command at a time:
//   - copy mode: move cmd_len 32-bit words from cmd_src to cmd_dst (one read, then one write, per word).
//   - fill mode: write cmd_pattern to cmd_len words starting at cmd_dst.
//  Intended use: simulation/boot-time preload and block moves in front of the word memory responder.
// PARAMETERS
//  LEN_W    16   width of cmd_len (max words per command = 2^LEN_W-1)
//  TIMEOUT  255  max cycles a request may wait for ready before abort; 0 = never abort
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  reset        in   1      synchronous, active-high reset
//  cmd_valid    in   1      command request
//  cmd_ready    out  1      high in IDLE; command accepted on cmd_valid&&cmd_ready
//  cmd_fill     in   1      1 = fill mode, 0 = copy mode
//  cmd_src      in   32     copy source byte address; [1:0] ignored
//  cmd_dst      in   32     destination byte address; [1:0] ignored
//  cmd_len      in   LEN_W  word count
//  cmd_pattern  in   32     fill data
//  busy         out  1      command in progress
//  done         out  1      one-cycle pulse when a command completes or aborts
//  err          out  1      valid with done: 1 = aborted on timeout
//  mem_valid    out  1      bus request
//  mem_ready    in   1      bus completion; single-cycle pulse from responder
//  mem_addr     out  32     word-aligned byte address; [1:0] always 00
//  mem_rdata    in   32     read data, sampled when mem_ready=1 during a read
//  mem_wdata    out  32     write data
//  mem_wstrb    out  4      4'b0000 = read, 4'b1111 = write (no other values driven)
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset values: cmd_ready=0 during reset, then 1; busy=0, done=0, err=0, mem_valid=0.
//    Reset values: mem_addr=0, mem_wdata=0, mem_wstrb=0.
//  - Reset mid-command: mem_valid=0 at the edge. No done pulse. The command is dropped.
//  - States: IDLE, RD, WR.
//    - IDLE: cmd_ready=1. On accept, capture src/dst/len/fill/pattern.
//      - len=0: stay IDLE and pulse done (err=0) in the next cycle. No bus activity.
//      - fill=1: go to WR.
//      - fill=0: go to RD.
//    - RD: mem_valid=1, wstrb=0000, addr=src.
//      - On the edge sampling mem_ready=1: latch rdata into mem_wdata, src+=4, go to WR.
//    - WR: mem_valid=1, wstrb=1111, addr=dst, wdata = latched data (copy) or pattern (fill).
//      - On ready: dst+=4, len-=1.
//      - If the new len=0: go IDLE and pulse done (err=0).
//      - Otherwise go to RD (copy) or stay in WR (fill).
//  - Handshake rules:
//    - mem_valid, addr, wdata and wstrb are registered and held stable until the edge that samples ready.
//    - The next request may be driven in the cycle right after ready (back-to-back).
//    - If no request follows, mem_valid is 0 in the cycle after ready.
//    - The responder must never see valid held over its ready cycle for the same request.
//  - Latency against a 1-wait responder (ready one cycle after valid is seen):
//    - Command accepted at edge 0.
//    - Copy: 4 cycles per word; done high in the cycle after edge 4N.
//    - Fill: 2 cycles per word; done high in the cycle after edge 2N.
//  - Address arithmetic: 32-bit, +4 per word, wraps modulo 2^32 with no error.
//  - Timeout (TIMEOUT>0):
//    - wait_cnt clears when each request is issued and counts edges with mem_valid=1 and mem_ready=0.
//    - When it reaches TIMEOUT: mem_valid=0, go IDLE, pulse done with err=1.
//    - A ready arriving on that same edge wins; no abort.
//  - busy = (state != IDLE). done and err are 0 outside the done pulse.
//  - cmd_valid while busy is ignored; no queuing.
// TESTING
//  1. Copy: src=0x100, dst=0x200, len=3, mem[0x100..]=A,B,C.
//     -> mem[0x200..]=A,B,C; wstrb sequence 0,F,0,F,0,F; done after edge 12, err=0.
//  2. Fill: dst=0x40, len=4, pattern=0xDEADBEEF.
//     -> four writes to 0x40/44/48/4C, no reads; done after edge 8.
//  3. len=0 in each mode -> mem_valid stays 0; done pulses one cycle after accept; cmd_ready back to 1.
//  4. TIMEOUT=8, responder never asserts ready.
//     -> mem_valid high exactly 8 cycles; then done=1, err=1; busy=0.
//  5. Assert reset during the second write of test 1.
//     -> mem_valid=0 the next cycle; no done pulse; a new command is accepted after reset.
//  6. Copy src=0xFFFFFFFC, len=2 -> reads at 0xFFFFFFFC, then 0x00000000; done, err=0.

Source files
------------

// File: rtl/mem_copy_master_if.sv
// Word-memory port: master issues valid/addr/wdata/wstrb, slave answers with a one-cycle
// ready pulse and rdata for reads.
interface mem_copy_master_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  modport master (
    output valid,
    output addr,
    output wdata,
    output wstrb,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  addr,
    input  wdata,
    input  wstrb,
    output ready,
    output rdata
  );
endinterface

// File: rtl/mem_copy_master.sv
// Bus initiator that copies a block of words (read then write per word) or fills a block with a
// pattern, one command at a time, with an optional per-request ready timeout.
module mem_copy_master #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_fill_i,
  input  logic [31:0]          cmd_src_i,
  input  logic [31:0]          cmd_dst_i,
  input  logic [LEN_W-1:0]     cmd_len_i,
  input  logic [31:0]          cmd_pattern_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  mem_copy_master_if.master    mem_bus
);

  localparam int unsigned WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] AddrMask = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e           state_q;
  logic             cmd_ready_q, done_q, err_q, fill_q;
  logic             valid_q;
  logic [31:0]      addr_q, wdata_q, src_q, dst_q;
  logic [3:0]       wstrb_q;
  logic [LEN_W-1:0] len_q;
  logic [WaitW-1:0] wait_q;
  logic             timed_out;
  logic [31:0]      src_inc, dst_inc;

  assign src_inc   = src_q + 32'd4;
  assign dst_inc   = dst_q + 32'd4;
  // The edge that would push the wait count to TIMEOUT aborts; ready on that edge takes priority.
  assign timed_out = (TIMEOUT != 0) && (wait_q == WaitW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fill_q      <= 1'b0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      wait_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            src_q  <= cmd_src_i & AddrMask;
            dst_q  <= cmd_dst_i & AddrMask;
            len_q  <= cmd_len_i;
            fill_q <= cmd_fill_i;
            wait_q <= '0;
            if (cmd_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              cmd_ready_q <= 1'b0;
              valid_q     <= 1'b1;
              if (cmd_fill_i) begin
                state_q <= StWr;
                addr_q  <= cmd_dst_i & AddrMask;
                wstrb_q <= 4'hF;
                wdata_q <= cmd_pattern_i;
              end else begin
                state_q <= StRd;
                addr_q  <= cmd_src_i & AddrMask;
                wstrb_q <= 4'h0;
              end
            end
          end
        end
        default: begin
          if (!mem_bus.ready) begin
            if (timed_out) begin
              valid_q     <= 1'b0;
              state_q     <= StIdle;
              done_q      <= 1'b1;
              err_q       <= 1'b1;
              cmd_ready_q <= 1'b1;
            end else begin
              wait_q <= wait_q + 1'b1;
            end
          end else if (state_q == StRd) begin
            wait_q  <= '0;
            wdata_q <= mem_bus.rdata;
            src_q   <= src_inc;
            state_q <= StWr;
            addr_q  <= dst_q;
            wstrb_q <= 4'hF;
          end else begin
            wait_q <= '0;
            dst_q  <= dst_inc;
            len_q  <= len_q - 1'b1;
            if (len_q == LEN_W'(1)) begin
              valid_q     <= 1'b0;
              state_q     <= StIdle;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
            end else if (fill_q) begin
              addr_q <= dst_inc;
            end else begin
              state_q <= StRd;
              addr_q  <= src_q;
              wstrb_q <= 4'h0;
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign mem_bus.valid = valid_q;
  assign mem_bus.addr  = addr_q;
  assign mem_bus.wdata = wdata_q;
  assign mem_bus.wstrb = wstrb_q;

endmodule
